// File: rtl/offset_bit_decoder_pkg.sv
// Shared constants for the constant-offset bit encoder/decoder pair.
package offset_bit_decoder_pkg;

  localparam int unsigned WIDTH_DEF      = 8;
  localparam int unsigned FRAME_BITS_DEF = 8;
  localparam logic [7:0]  BASE_CONST_DEF = 8'hAE;

  // COLLECT: buffer empty or draining this cycle. FULL: a finished frame is unread.
  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } dec_state_e;

endpackage

// File: rtl/offset_symbol_check.sv
// Combinational decode of one (sum, base) symbol into a bit plus a bad-symbol flag.
module offset_symbol_check
  import offset_bit_decoder_pkg::*;
#(
  parameter int unsigned      WIDTH      = WIDTH_DEF,
  parameter logic [WIDTH-1:0] BASE_CONST = WIDTH'(BASE_CONST_DEF),
  parameter bit               CHECK_BASE = 1'b1
) (
  input  logic [WIDTH-1:0] sum,
  input  logic [WIDTH-1:0] base,
  output logic             bit_val,
  output logic             bad
);

  logic [WIDTH-1:0] diff;
  logic             base_bad;

  always_comb begin
    // Modular subtraction, so sum 8'h00 over base 8'hFF decodes as 1.
    diff     = sum - base;
    bit_val  = diff[0];
    base_bad = CHECK_BASE && (base != BASE_CONST);
    bad      = (diff > WIDTH'(1)) || base_bad;
  end

endmodule

// File: rtl/offset_bit_decoder.sv
// Recovers bits from (sum, base) symbols, packs them LSB-first into frames
// and holds each finished frame in a single-entry valid/ready buffer.
module offset_bit_decoder
  import offset_bit_decoder_pkg::*;
#(
  parameter int unsigned      WIDTH      = WIDTH_DEF,
  parameter int unsigned      FRAME_BITS = FRAME_BITS_DEF,
  parameter logic [WIDTH-1:0] BASE_CONST = WIDTH'(BASE_CONST_DEF),
  parameter bit               CHECK_BASE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_sum,
  input  logic [WIDTH-1:0]      in_base,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FRAME_BITS-1:0] out_byte,
  output logic [3:0]            bit_count,
  output logic                  sym_err,
  input  logic                  err_clr
);

  dec_state_e            state;
  logic                  sym_bit;
  logic                  sym_bad;
  logic                  accept;
  logic                  good_acc;
  logic                  bad_acc;
  logic                  last_bit;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] bit_mask;
  logic [FRAME_BITS-1:0] frame_next;

  offset_symbol_check #(
    .WIDTH      (WIDTH),
    .BASE_CONST (BASE_CONST),
    .CHECK_BASE (CHECK_BASE)
  ) u_check (
    .sum     (in_sum),
    .base    (in_base),
    .bit_val (sym_bit),
    .bad     (sym_bad)
  );

  always_comb begin
    state      = (out_valid && !out_ready) ? ST_FULL : ST_COLLECT;
    in_ready   = (state == ST_COLLECT);
    accept     = in_valid && in_ready;
    good_acc   = accept && !sym_bad;
    bad_acc    = accept && sym_bad;
    last_bit   = (bit_count == 4'(FRAME_BITS - 1));
    // Mask-based insert at position bit_count avoids a narrow-index bit select.
    bit_mask   = FRAME_BITS'(1) << bit_count;
    frame_next = sym_bit ? (shift_q | bit_mask) : (shift_q & ~bit_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_byte  <= '0;
      bit_count <= '0;
      shift_q   <= '0;
      sym_err   <= 1'b0;
    end else begin
      if (bad_acc) begin
        sym_err <= 1'b1;
      end else if (err_clr) begin
        sym_err <= 1'b0;
      end

      if (good_acc) begin
        if (last_bit) begin
          out_byte  <= frame_next;
          shift_q   <= '0;
          bit_count <= '0;
        end else begin
          shift_q   <= frame_next;
          bit_count <= bit_count + 4'd1;
        end
      end

      if (good_acc && last_bit) begin
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/offset_bit_decoder.md
Name: offset_bit_decoder

Overview:
- Receive-side partner of the constant-offset bit encoder. The encoder emits sum = base + bit with base = 8'hAE; this block recovers each bit as sum - base.
- Recovered bits are deserialized LSB-first into bytes.
- Each completed byte is presented on a single-entry valid/ready output buffer.
- Sits between the encoder output pair (sum, base) and downstream byte consumers.

Parameters:
- WIDTH, 8, width of sum/base words.
- FRAME_BITS, 8, bits per output frame; out_byte width equals FRAME_BITS.
- BASE_CONST, 8'hAE, expected base value.
- CHECK_BASE, 1, when 1, a base word different from BASE_CONST is a symbol error.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  sum/base symbol present
- in_ready  output  1  symbol accepted this cycle when in_valid & in_ready
- in_sum  input  WIDTH  encoded word (base + bit)
- in_base  input  WIDTH  base word sent alongside
- out_valid  output  1  completed frame available
- out_ready  input  1  consumer takes frame when out_valid & out_ready
- out_byte  output  FRAME_BITS  decoded frame, bit 0 = first received bit
- bit_count  output  4  good bits collected in current frame (0..FRAME_BITS-1)
- sym_err  output  1  sticky symbol-error flag
- err_clr  input  1  synchronous clear of sym_err

Behaviour:
- Reset (async, active-high): out_valid=0, out_byte=0, bit_count=0, shift register=0, sym_err=0. Reset mid-frame discards partial bits.
- Handshake
  - in_ready = ~(out_valid & ~out_ready). The block stalls only while a finished frame is unread.
  - in_valid may be held for any number of cycles; a symbol is consumed exactly once per accept cycle.
- Decode on accept
  - diff = (in_sum - in_base) mod 2^WIDTH, WIDTH-bit wrap-around.
  - diff==0 gives bit 0; diff==1 gives bit 1. Wrap case: sum 8'h00 with base 8'hFF gives 1.
  - A symbol is bad if diff>1, or if CHECK_BASE=1 and in_base != BASE_CONST.
  - Bad symbol: sym_err<=1; shift register and bit_count unchanged; the symbol is dropped.
- Collection
  - Good bit: written to shift-register position bit_count; bit_count increments.
  - When bit_count==FRAME_BITS-1 and a good bit is accepted:
    - out_byte <= assembled frame, including the new bit.
    - out_valid <= 1 on the next edge.
    - bit_count <= 0.
  - Latency: out_valid rises 1 cycle after the accepting edge of the last bit.
- Output
  - out_valid and out_byte stay stable until out_valid & out_ready.
  - Consumption clears out_valid next edge, unless a new frame completes in the same cycle.
- Simultaneous events
  - Output consumed and last bit of next frame accepted in the same cycle: out_byte loads the new frame and out_valid stays 1.
  - err_clr together with a bad symbol: set wins, so sym_err=1.
- States: COLLECT (bit_count<FRAME_BITS, out buffer empty or draining) and FULL (out_valid & ~out_ready, in_ready=0).
  - COLLECT to FULL: frame completes and out_ready=0.
  - FULL to COLLECT: out_ready=1.
  - The state is implicit in out_valid; no separate encoding is required.

Decomposition:
- Shared package: BASE_CONST default (8'hAE), WIDTH and FRAME_BITS defaults. The encoder uses the same constant.
- One natural sub-module, offset_symbol_check: combinational diff, bit and bad computation.
- Shift/count/output-buffer logic stays in the top module.

Test Plan:
1. Reset, then symbols (sum,base) = (AF,AE),(AE,AE),(AF,AE),(AF,AE),(AE,AE),(AE,AE),(AE,AE),(AF,AE) with out_ready=1 → out_valid pulses one cycle after the 8th accept; out_byte=8'h8D; sym_err=0.
2. Send (B0,AE) mid-frame after 3 good bits → sym_err=1; bit_count stays 3; the frame completes after 5 more good bits. err_clr for one cycle → sym_err=0.
3. CHECK_BASE=0, symbols (00,FF) ×8 → out_byte=8'hFF (wrap decode). With CHECK_BASE=1 the same stimulus → sym_err=1 and no frame.
4. Backpressure: complete frame 8'h55 with out_ready=0 → in_ready=0 and out_byte holds 8'h55 for 10 cycles while in_valid=1. Raise out_ready → in_ready=1 next cycle; no symbol is lost.
5. Back-to-back: out_ready=1 and in_valid=1 continuously for 16 good symbols → two frames, out_valid high exactly 1 cycle each; second byte correct with no gap error.
6. Assert reset after 5 bits mid-frame, release, then send 8 bits of 8'hC3 → out_byte=8'hC3; the earlier partial bits do not appear.
